// File: rtl/elevator_call_arbiter.sv
// SCAN-policy call arbiter for a 4-floor elevator: latches call buttons and hands target floors
// to the controller over a valid/ack handshake. Optional debounce via `define CALL_DEBOUNCE_EN.
module elevator_call_arbiter #(
    parameter int unsigned SYNC_STAGES = 2
`ifdef CALL_DEBOUNCE_EN
    ,
    parameter int unsigned DB_CYCLES = 8
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn,
    input  logic       req_ack,
    output logic [1:0] R,
    output logic       req_valid,
    output logic [3:0] pending,
    output logic       dir_up
);
    typedef enum logic [1:0] {StIdle, StSel, StWait} state_e;

    logic [SYNC_STAGES-1:0][3:0] r_sync;
    logic [3:0]                  w_level;
    logic [3:0]                  r_prev;
    logic [3:0]                  w_rise;
    state_e                      r_state, w_state_next;
    logic [3:0]                  r_pending, w_pending_next;
    logic [1:0]                  r_target, w_target_next;
    logic [1:0]                  r_cur_floor, w_cur_next;
    logic                        r_valid, w_valid_next;
    logic                        r_dir_up, w_dir_next;
    logic                        w_handshake;
    logic [1:0]                  w_above, w_below, w_pick;
    logic                        w_has_above, w_has_below, w_pick_dir;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], btn};
        end
    end

`ifdef CALL_DEBOUNCE_EN
    localparam int unsigned CntW = $clog2(DB_CYCLES + 1);

    logic [3:0][CntW-1:0] r_db_cnt;
    logic [3:0]           r_filt;

    // Counter tracks consecutive cycles the synchronized level disagrees with the filtered one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db_cnt <= '0;
            r_filt   <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (r_sync[SYNC_STAGES-1][i] == r_filt[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == CntW'(DB_CYCLES - 1)) begin
                    r_db_cnt[i] <= '0;
                    r_filt[i]   <= r_sync[SYNC_STAGES-1][i];
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + CntW'(1);
                end
            end
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = r_sync[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= '0;
        end else begin
            r_prev <= w_level;
        end
    end

    assign w_rise      = w_level & ~r_prev;
    assign w_handshake = r_valid & req_ack;

    // Nearest pending floor strictly above / below the current floor.
    always_comb begin
        w_has_above = 1'b0;
        w_above     = r_cur_floor;
        w_has_below = 1'b0;
        w_below     = r_cur_floor;
        for (int f = 3; f >= 0; f--) begin
            if (f > int'(r_cur_floor) && r_pending[f]) begin
                w_has_above = 1'b1;
                w_above     = 2'(f);
            end
        end
        for (int f = 0; f < 4; f++) begin
            if (f < int'(r_cur_floor) && r_pending[f]) begin
                w_has_below = 1'b1;
                w_below     = 2'(f);
            end
        end
    end

    always_comb begin
        w_pick     = r_cur_floor;
        w_pick_dir = r_dir_up;
        if (!r_pending[r_cur_floor]) begin
            if (r_dir_up) begin
                if (w_has_above) begin
                    w_pick = w_above;
                end else if (w_has_below) begin
                    w_pick     = w_below;
                    w_pick_dir = 1'b0;
                end
            end else begin
                if (w_has_below) begin
                    w_pick = w_below;
                end else if (w_has_above) begin
                    w_pick     = w_above;
                    w_pick_dir = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_target_next  = r_target;
        w_valid_next   = r_valid;
        w_dir_next     = r_dir_up;
        w_cur_next     = r_cur_floor;
        w_pending_next = r_pending | w_rise;
        // Arrival serves the floor, so a same-cycle press for it is dropped.
        if (w_handshake) begin
            w_pending_next[r_target] = 1'b0;
        end
        unique case (r_state)
            StIdle: begin
                if (r_pending != '0) begin
                    w_state_next = StSel;
                end
            end
            StSel: begin
                if (r_pending == '0) begin
                    w_state_next = StIdle;
                end else begin
                    w_target_next = w_pick;
                    w_dir_next    = w_pick_dir;
                    w_valid_next  = 1'b1;
                    w_state_next  = StWait;
                end
            end
            StWait: begin
                if (w_handshake) begin
                    w_valid_next = 1'b0;
                    w_cur_next   = r_target;
                    w_state_next = (w_pending_next != '0) ? StSel : StIdle;
                end
            end
            default: begin
                w_valid_next = 1'b0;
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_pending   <= '0;
            r_target    <= '0;
            r_valid     <= 1'b0;
            r_dir_up    <= 1'b1;
            r_cur_floor <= '0;
        end else begin
            r_state     <= w_state_next;
            r_pending   <= w_pending_next;
            r_target    <= w_target_next;
            r_valid     <= w_valid_next;
            r_dir_up    <= w_dir_next;
            r_cur_floor <= w_cur_next;
        end
    end

    assign R         = r_target;
    assign req_valid = r_valid;
    assign pending   = r_pending;
    assign dir_up    = r_dir_up;

endmodule

// File: tb/tb_elevator_call_arbiter.sv
// Bench for elevator_call_arbiter: directed SCAN scenarios plus random presses/acks, every
// cycle compared against a floor-distance reference model.
module tb_elevator_call_arbiter;
    localparam int SYNC = 2;
`ifdef CALL_DEBOUNCE_EN
    localparam int DB = 8;
`else
    localparam int DB = 0;
`endif
    localparam int PH_IDLE = 0;
    localparam int PH_SEL  = 1;
    localparam int PH_WAIT = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn;
    logic       req_ack;
    logic [1:0] R;
    logic       req_valid;
    logic [3:0] pending;
    logic       dir_up;

    int total = 0;
    int bad   = 0;

    elevator_call_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn      (btn),
        .req_ack  (req_ack),
        .R        (R),
        .req_valid(req_valid),
        .pending  (pending),
        .dir_up   (dir_up)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [3:0] m_sync [SYNC];
    logic [3:0] m_prev, m_pend;
    logic [1:0] m_R, m_cur;
    logic       m_valid, m_dir;
    int         m_phase;
`ifdef CALL_DEBOUNCE_EN
    logic [3:0] m_filt;
    int         m_run [4];
`endif

    function automatic void model_reset();
        for (int k = 0; k < SYNC; k++) m_sync[k] = '0;
        m_prev  = '0;
        m_pend  = '0;
        m_R     = '0;
        m_cur   = '0;
        m_valid = 1'b0;
        m_dir   = 1'b1;
        m_phase = PH_IDLE;
`ifdef CALL_DEBOUNCE_EN
        m_filt = '0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
`endif
    endfunction

    // Preferred-direction calls rank by distance; calls only behind rank after all of them.
    function automatic void model_pick();
        int best, best_key, d, key;
        best     = int'(m_cur);
        best_key = 99;
        for (int f = 0; f < 4; f++) begin
            if (m_pend[f]) begin
                d = f - int'(m_cur);
                if (d == 0) key = 0;
                else if ((d > 0) == m_dir) key = (d > 0) ? d : -d;
                else key = 4 + ((d > 0) ? d : -d);
                if (key < best_key) begin
                    best_key = key;
                    best     = f;
                end
            end
        end
        if (best != int'(m_cur) && ((best > int'(m_cur)) != m_dir)) m_dir = ~m_dir;
        m_R = 2'(best);
    endfunction

    function automatic void model_edge(input logic [3:0] b, input logic a);
        logic [3:0] lvl, rise, np;
        logic       hs;
`ifdef CALL_DEBOUNCE_EN
        lvl = m_filt;
`else
        lvl = m_sync[SYNC-1];
`endif
        rise = lvl & ~m_prev;
        hs   = m_valid & a;
        np   = m_pend | rise;
        if (hs) np[m_R] = 1'b0;
        case (m_phase)
            PH_IDLE: if (m_pend != 0) m_phase = PH_SEL;
            PH_SEL: begin
                if (m_pend == 0) m_phase = PH_IDLE;
                else begin
                    model_pick();
                    m_valid = 1'b1;
                    m_phase = PH_WAIT;
                end
            end
            default: begin
                if (hs) begin
                    m_valid = 1'b0;
                    m_cur   = m_R;
                    m_phase = (np != 0) ? PH_SEL : PH_IDLE;
                end
            end
        endcase
        m_pend = np;
        m_prev = lvl;
`ifdef CALL_DEBOUNCE_EN
        for (int i = 0; i < 4; i++) begin
            if (m_sync[SYNC-1][i] != m_filt[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    m_filt[i] = m_sync[SYNC-1][i];
                    m_run[i]  = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
`endif
        for (int k = SYNC - 1; k > 0; k--) m_sync[k] = m_sync[k-1];
        m_sync[0] = b;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, "_R"}, int'(R), int'(m_R));
        chk({tag, "_req_valid"}, int'(req_valid), int'(m_valid));
        chk({tag, "_pending"}, int'(pending), int'(m_pend));
        chk({tag, "_dir_up"}, int'(dir_up), int'(m_dir));
    endtask

    task automatic step();
        logic [3:0] b;
        logic       a;
        b = btn;
        a = req_ack;
        @(posedge clk);
        #1;
        model_edge(b, a);
        compare_all("model");
    endtask

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        while (req_valid !== 1'b1 && k < 40) begin
            step();
            k++;
        end
        chk({tag, "_valid_timeout"}, int'(req_valid), 1);
    endtask

    task automatic ack_once();
        req_ack = 1'b1;
        step();
        req_ack = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        rst_n   = 1'b0;
        btn     = '0;
        req_ack = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_R"}, int'(R), 0);
        chk({tag, "_req_valid"}, int'(req_valid), 0);
        chk({tag, "_pending"}, int'(pending), 0);
        chk({tag, "_dir_up"}, int'(dir_up), 1);
    endtask

    initial begin
        rst_n   = 1'b0;
        btn     = '0;
        req_ack = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        #3;
        rst_n = 1'b1;
        step();
        step();

        // T1: asynchronous reset while waiting on R=2
        btn = 4'b0100;
        wait_valid("t1");
        chk("t1_R", int'(R), 2);
        btn = '0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("t1_async");
        model_reset();
        #1;
        rst_n = 1'b1;
        repeat (6) step();
        chk("t1_quiet", int'(req_valid), 0);

        // T2: single call from floor 0
        btn = 4'b1000;
        wait_valid("t2");
        chk("t2_R", int'(R), 3);
        chk("t2_pend", int'(pending), 8);
        btn = '0;
        ack_once();
        chk("t2_pend_clr", int'(pending), 0);
        chk("t2_valid_clr", int'(req_valid), 0);
        repeat (4) step();
        chk("t2_idle", int'(req_valid), 0);

        // T3: SCAN order from c=1 going up with calls at 0,2,3
        do_reset();
        btn = 4'b0010;
        wait_valid("t3_setup");
        chk("t3_setup_R", int'(R), 1);
        btn = '0;
        ack_once();
        btn = 4'b1101;
        wait_valid("t3a");
        chk("t3a_R", int'(R), 2);
        chk("t3a_pend", int'(pending), 13);
        btn = '0;
        ack_once();
        wait_valid("t3b");
        chk("t3b_R", int'(R), 3);
        ack_once();
        wait_valid("t3c");
        chk("t3c_R", int'(R), 0);
        chk("t3c_dir", int'(dir_up), 0);
        ack_once();

        // T4: closer call while waiting does not preempt
        btn = 4'b1000;
        wait_valid("t4a");
        chk("t4a_R", int'(R), 3);
        chk("t4a_dir", int'(dir_up), 1);
        btn = '0;
        step();
        btn = 4'b0100;
        repeat (10 + DB) step();
        chk("t4_hold_R", int'(R), 3);
        chk("t4_hold_valid", int'(req_valid), 1);
        chk("t4_hold_pend", int'(pending), 12);
        btn = '0;
        ack_once();
        wait_valid("t4b");
        chk("t4b_R", int'(R), 2);
        ack_once();

        // T5: press edges land in the ack cycle
        btn = 4'b1000;
        wait_valid("t5");
        chk("t5_R", int'(R), 3);
        btn = '0;
        repeat (SYNC + DB + 3) step();
        btn = 4'b1010;
        repeat (SYNC + DB) step();
        ack_once();
        chk("t5_pend", int'(pending), 2);
        chk("t5_valid", int'(req_valid), 0);
        btn = '0;
        wait_valid("t5b");
        chk("t5b_R", int'(R), 1);
        ack_once();
        repeat (3) step();
        chk("t5_no_rereq", int'(pending), 0);

        // T6: short pulse
        btn = 4'b0001;
        repeat (5) step();
        btn = '0;
`ifdef CALL_DEBOUNCE_EN
        repeat (12) step();
        chk("t6_glitch", int'(pending), 0);
        btn = 4'b0001;
        repeat (12) step();
        btn = '0;
        chk("t6_press", int'(pending[0]), 1);
`else
        repeat (4) step();
        chk("t6_pulse", int'(pending[0]), 1);
`endif
        wait_valid("t6");
        ack_once();

        // Random presses and acks
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                int b;
                b      = int'($urandom_range(0, 3));
                btn[b] = ~btn[b];
            end
            req_ack = ($urandom_range(0, 3) == 0);
            step();
        end
        req_ack = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
